// File: rtl/edit_mem_shared_memory_mc.sv
// Shared edit-memory packet buffer: PU write path, NUM_RD round-robin read
// channels, same-cycle write-to-read forwarding and buffer release.
module edit_mem_shared_memory_mc #(
    parameter int BPTR_NBITS     = 10,
    parameter int BPTR_LSB_NBITS = 2,
    parameter int DATA_NBITS     = 512,
    parameter int ID_NBITS       = 3,
    parameter int NUM_RD         = 4,
    localparam int CH_NBITS      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               pu_data_valid,
    input  logic [BPTR_NBITS-1:0]              pu_data_buf_ptr,
    input  logic [BPTR_LSB_NBITS-1:0]          pu_data_buf_ptr_lsb,
    input  logic [DATA_NBITS-1:0]              pu_data,
    input  logic [NUM_RD-1:0]                  rd_req,
    input  logic [NUM_RD*ID_NBITS-1:0]         rd_dst_port_id,
    input  logic [NUM_RD-1:0]                  rd_sop,
    input  logic [NUM_RD-1:0]                  rd_eop,
    input  logic [NUM_RD*BPTR_NBITS-1:0]       rd_buf_ptr,
    input  logic [NUM_RD*BPTR_LSB_NBITS-1:0]   rd_buf_ptr_lsb,
    output logic [NUM_RD-1:0]                  rd_gnt,
    output logic                               edit_mem_ack,
    output logic [CH_NBITS-1:0]                edit_mem_ack_ch,
    output logic [ID_NBITS-1:0]                edit_mem_dst_port_id,
    output logic                               edit_mem_sop,
    output logic                               edit_mem_eop,
    output logic [DATA_NBITS-1:0]              edit_mem_rdata,
    output logic                               em_rel_buf_valid,
    output logic [BPTR_NBITS-1:0]              em_rel_buf_ptr
);

    localparam int A_NBITS = BPTR_NBITS + BPTR_LSB_NBITS;

    logic [DATA_NBITS-1:0]     mem [2**A_NBITS];

    logic                      w1_valid;
    logic [A_NBITS-1:0]        w1_addr;
    logic [DATA_NBITS-1:0]     w1_data;

    logic [CH_NBITS-1:0]       rr_ptr;
    logic                      gnt_any;
    logic [CH_NBITS-1:0]       gnt_ch;
    logic [ID_NBITS-1:0]       sel_id;
    logic                      sel_sop;
    logic                      sel_eop;
    logic [BPTR_NBITS-1:0]     sel_ptr;
    logic [BPTR_LSB_NBITS-1:0] sel_lsb;
    int                        arb_idx;

    logic                      r1_valid;
    logic [CH_NBITS-1:0]       r1_ch;
    logic [ID_NBITS-1:0]       r1_id;
    logic                      r1_sop;
    logic                      r1_eop;
    logic [BPTR_NBITS-1:0]     r1_ptr;
    logic [BPTR_LSB_NBITS-1:0] r1_lsb;
    logic [A_NBITS-1:0]        r1_addr;
    logic                      fwd;

    assign r1_addr = {r1_ptr, r1_lsb};
    assign fwd     = r1_valid && w1_valid && (r1_addr == w1_addr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w1_valid <= 1'b0;
        end else begin
            w1_valid <= pu_data_valid;
            w1_addr  <= {pu_data_buf_ptr, pu_data_buf_ptr_lsb};
            w1_data  <= pu_data;
        end
    end

    // A write still in W1 when reset hits is dropped with the rest of the pipe.
    always_ff @(posedge clk) begin
        if (rstn && w1_valid)
            mem[w1_addr] <= w1_data;
    end

    always_comb begin
        rd_gnt  = '0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        sel_id  = '0;
        sel_sop = 1'b0;
        sel_eop = 1'b0;
        sel_ptr = '0;
        sel_lsb = '0;
        arb_idx = 0;
        for (int i = 0; i < NUM_RD; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_RD)
                arb_idx = arb_idx - NUM_RD;
            if (rstn && !gnt_any && rd_req[arb_idx]) begin
                gnt_any         = 1'b1;
                gnt_ch          = CH_NBITS'(arb_idx);
                rd_gnt[arb_idx] = 1'b1;
                sel_id  = rd_dst_port_id[arb_idx*ID_NBITS +: ID_NBITS];
                sel_sop = rd_sop[arb_idx];
                sel_eop = rd_eop[arb_idx];
                sel_ptr = rd_buf_ptr[arb_idx*BPTR_NBITS +: BPTR_NBITS];
                sel_lsb = rd_buf_ptr_lsb[arb_idx*BPTR_LSB_NBITS +: BPTR_LSB_NBITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr   <= '0;
            r1_valid <= 1'b0;
            r1_ch    <= '0;
            r1_id    <= '0;
            r1_sop   <= 1'b0;
            r1_eop   <= 1'b0;
            r1_ptr   <= '0;
            r1_lsb   <= '0;
        end else begin
            r1_valid <= gnt_any;
            if (gnt_any) begin
                rr_ptr <= (gnt_ch == CH_NBITS'(NUM_RD - 1)) ? '0 : gnt_ch + 1'b1;
                r1_ch  <= gnt_ch;
                r1_id  <= sel_id;
                r1_sop <= sel_sop;
                r1_eop <= sel_eop;
                r1_ptr <= sel_ptr;
                r1_lsb <= sel_lsb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            edit_mem_ack         <= 1'b0;
            edit_mem_ack_ch      <= '0;
            edit_mem_dst_port_id <= '0;
            edit_mem_sop         <= 1'b0;
            edit_mem_eop         <= 1'b0;
            edit_mem_rdata       <= '0;
            em_rel_buf_valid     <= 1'b0;
            em_rel_buf_ptr       <= '0;
        end else begin
            edit_mem_ack     <= r1_valid;
            em_rel_buf_valid <= r1_valid && ((&r1_lsb) || r1_eop);
            if (r1_valid) begin
                edit_mem_ack_ch      <= r1_ch;
                edit_mem_dst_port_id <= r1_id;
                edit_mem_sop         <= r1_sop;
                edit_mem_eop         <= r1_eop;
                edit_mem_rdata       <= fwd ? w1_data : mem[r1_addr];
                em_rel_buf_ptr       <= r1_ptr;
            end
        end
    end

endmodule

// File: tb/tb_edit_mem_shared_memory_mc.sv
// Bench for edit_mem_shared_memory_mc: scoreboard of grants vs acks,
// release table, forwarding, round-robin and mid-stream reset sequences.
module tb_edit_mem_shared_memory_mc;

    localparam int NR = 4;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rstn;
    logic            pu_data_valid;
    logic [9:0]      pu_data_buf_ptr;
    logic [1:0]      pu_data_buf_ptr_lsb;
    logic [DW-1:0]   pu_data;
    logic [NR-1:0]   rd_req;
    logic [NR*3-1:0] rd_dst_port_id;
    logic [NR-1:0]   rd_sop;
    logic [NR-1:0]   rd_eop;
    logic [NR*10-1:0] rd_buf_ptr;
    logic [NR*2-1:0] rd_buf_ptr_lsb;
    logic [NR-1:0]   rd_gnt;
    logic            edit_mem_ack;
    logic [1:0]      edit_mem_ack_ch;
    logic [2:0]      edit_mem_dst_port_id;
    logic            edit_mem_sop;
    logic            edit_mem_eop;
    logic [DW-1:0]   edit_mem_rdata;
    logic            em_rel_buf_valid;
    logic [9:0]      em_rel_buf_ptr;

    edit_mem_shared_memory_mc dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .pu_data_valid        (pu_data_valid),
        .pu_data_buf_ptr      (pu_data_buf_ptr),
        .pu_data_buf_ptr_lsb  (pu_data_buf_ptr_lsb),
        .pu_data              (pu_data),
        .rd_req               (rd_req),
        .rd_dst_port_id       (rd_dst_port_id),
        .rd_sop               (rd_sop),
        .rd_eop               (rd_eop),
        .rd_buf_ptr           (rd_buf_ptr),
        .rd_buf_ptr_lsb       (rd_buf_ptr_lsb),
        .rd_gnt               (rd_gnt),
        .edit_mem_ack         (edit_mem_ack),
        .edit_mem_ack_ch      (edit_mem_ack_ch),
        .edit_mem_dst_port_id (edit_mem_dst_port_id),
        .edit_mem_sop         (edit_mem_sop),
        .edit_mem_eop         (edit_mem_eop),
        .edit_mem_rdata       (edit_mem_rdata),
        .em_rel_buf_valid     (em_rel_buf_valid),
        .em_rel_buf_ptr       (em_rel_buf_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [2:0]  id;
        logic        sop;
        logic        eop;
        logic [9:0]  ptr;
        logic        rel;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int         ch;
        logic [9:0] ptr;
        logic [1:0] lsb;
        logic       sop;
        logic       eop;
        logic [2:0] id;
        logic       rel;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mptr = 0;
    bit in_rst_prev = 1'b1;
    exp_t q[$];
    exp_t e;
    logic [DW-1:0] mem_m [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: model arbiter and memory, checks every ack against its grant.
    always @(negedge clk) begin
        int eidx;
        int ch;
        logic [11:0] a;
        if (!rstn && in_rst_prev) begin
            chk("rst_ack", edit_mem_ack, 0);
            chk("rst_rel", em_rel_buf_valid, 0);
            chk("rst_rdata", edit_mem_rdata, 0);
            chk("rst_ch", edit_mem_ack_ch, 0);
        end else if (edit_mem_ack) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", edit_mem_ack, 0);
            end else begin
                e = q.pop_front();
                chk("ack_latency", cyc, e.cyc + 2);
                chk("ack_ch", edit_mem_ack_ch, e.ch);
                chk("ack_id", edit_mem_dst_port_id, e.id);
                chk("ack_sop", edit_mem_sop, e.sop);
                chk("ack_eop", edit_mem_eop, e.eop);
                chk("ack_rdata", edit_mem_rdata, e.data);
                chk("ack_rel", em_rel_buf_valid, e.rel);
                if (e.rel)
                    chk("rel_ptr", em_rel_buf_ptr, e.ptr);
            end
        end else begin
            chk("idle_rel", em_rel_buf_valid, 0);
        end
        if (!rstn) begin
            q.delete();
            mptr = 0;
            in_rst_prev = 1'b1;
        end else begin
            in_rst_prev = 1'b0;
            if (pu_data_valid)
                mem_m[int'({pu_data_buf_ptr, pu_data_buf_ptr_lsb})] = pu_data;
            eidx = -1;
            for (int i = 0; i < NR; i++) begin
                ch = (mptr + i) % NR;
                if (eidx < 0 && rd_req[ch])
                    eidx = ch;
            end
            if (rd_req != 0) begin
                chk("gnt", rd_gnt, NR'(1) << eidx);
                e.ch  = eidx;
                e.id  = rd_dst_port_id[eidx*3 +: 3];
                e.sop = rd_sop[eidx];
                e.eop = rd_eop[eidx];
                e.ptr = rd_buf_ptr[eidx*10 +: 10];
                a = {e.ptr, rd_buf_ptr_lsb[eidx*2 +: 2]};
                e.rel = (rd_buf_ptr_lsb[eidx*2 +: 2] == 2'd3) || e.eop;
                e.data = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
                e.cyc = cyc;
                q.push_back(e);
                mptr = (eidx + 1) % NR;
            end else begin
                chk("gnt_idle", rd_gnt, 0);
            end
        end
    end

    task automatic set_fields(input int ch, input logic [2:0] id, input logic sop,
                              input logic eop, input logic [9:0] ptr,
                              input logic [1:0] lsb);
        rd_dst_port_id[ch*3 +: 3]  = id;
        rd_sop[ch]                 = sop;
        rd_eop[ch]                 = eop;
        rd_buf_ptr[ch*10 +: 10]    = ptr;
        rd_buf_ptr_lsb[ch*2 +: 2]  = lsb;
    endtask

    task automatic write_word(input logic [9:0] ptr, input logic [1:0] lsb,
                              input logic [DW-1:0] d);
        pu_data_valid       = 1'b1;
        pu_data_buf_ptr     = ptr;
        pu_data_buf_ptr_lsb = lsb;
        pu_data             = d;
        tick();
        pu_data_valid = 1'b0;
    endtask

    task automatic issue_read(input int ch, input logic [2:0] id, input logic sop,
                              input logic eop, input logic [9:0] ptr,
                              input logic [1:0] lsb);
        bit got = 1'b0;
        set_fields(ch, id, sop, eop, ptr, lsb);
        rd_req[ch] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = rd_gnt[ch];
        end
        chk("grant_timeout", got, 1);
        tick();
        rd_req[ch] = 1'b0;
    endtask

    initial begin
        vec_t tbl[5];
        logic [DW-1:0] d;
        tbl[0] = '{ch: 0, ptr: 20, lsb: 3, sop: 0, eop: 0, id: 1, rel: 1};
        tbl[1] = '{ch: 1, ptr: 21, lsb: 1, sop: 0, eop: 1, id: 2, rel: 1};
        tbl[2] = '{ch: 2, ptr: 22, lsb: 3, sop: 1, eop: 1, id: 5, rel: 1};
        tbl[3] = '{ch: 1, ptr: 23, lsb: 0, sop: 0, eop: 0, id: 6, rel: 0};
        tbl[4] = '{ch: 3, ptr: 24, lsb: 2, sop: 1, eop: 0, id: 7, rel: 0};

        rstn = 1'b0;
        pu_data_valid = 1'b0;
        pu_data_buf_ptr = '0;
        pu_data_buf_ptr_lsb = '0;
        pu_data = '0;
        rd_req = '0;
        rd_dst_port_id = '0;
        rd_sop = '0;
        rd_eop = '0;
        rd_buf_ptr = '0;
        rd_buf_ptr_lsb = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        write_word(10'd5, 2'd0, {16{32'hA5A5A5A5}});
        tick();
        tick();
        issue_read(0, 3'd4, 1'b1, 1'b0, 10'd5, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("single_rdata", edit_mem_rdata, {16{32'hA5A5A5A5}});
        chk("single_norel", em_rel_buf_valid, 0);
        tick();

        for (int i = 0; i < 5; i++) begin
            d = {16{32'h5A000000 + i * 32'h01010101}};
            write_word(tbl[i].ptr, tbl[i].lsb, d);
            issue_read(tbl[i].ch, tbl[i].id, tbl[i].sop, tbl[i].eop,
                       tbl[i].ptr, tbl[i].lsb);
            @(negedge clk);
            @(negedge clk);
            chk("tbl_rdata", edit_mem_rdata, d);
            chk("tbl_rel", em_rel_buf_valid, tbl[i].rel);
            tick();
        end

        for (int c = 0; c < NR; c++)
            write_word(10'(30 + c), 2'd0, {16{32'hC0DE0000 + c}});
        for (int c = 0; c < NR; c++)
            set_fields(c, 3'(c), 1'b1, 1'b0, 10'(30 + c), 2'd0);
        rd_req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_seq", rd_gnt, NR'(1) << (k % NR));
        end
        tick();
        rd_req = '0;
        tick();

        write_word(10'd7, 2'd1, {16{32'h22222222}});
        tick();
        set_fields(1, 3'd1, 1'b0, 1'b0, 10'd7, 2'd1);
        rd_req = 4'b0010;
        tick();
        set_fields(2, 3'd2, 1'b0, 1'b0, 10'd7, 2'd1);
        rd_req = 4'b0100;
        pu_data_valid = 1'b1;
        pu_data_buf_ptr = 10'd7;
        pu_data_buf_ptr_lsb = 2'd1;
        pu_data = {16{32'h11111111}};
        tick();
        rd_req = '0;
        pu_data_valid = 1'b0;
        @(negedge clk);
        chk("fwd_old", edit_mem_rdata, {16{32'h22222222}});
        @(negedge clk);
        chk("fwd_new", edit_mem_rdata, {16{32'h11111111}});
        tick();
        tick();

        set_fields(2, 3'd2, 1'b0, 1'b1, 10'd32, 2'd0);
        set_fields(3, 3'd3, 1'b0, 1'b1, 10'd33, 2'd0);
        set_fields(0, 3'd0, 1'b0, 1'b0, 10'd30, 2'd0);
        rd_req = 4'b1100;
        tick();
        tick();
        rstn = 1'b0;
        rd_req = 4'b1101;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", rd_gnt, 4'b0001);
        tick();
        tick();
        rd_req = '0;

        for (int n = 0; n < 20 && q.size() != 0; n++)
            @(negedge clk);
        chk("drain", q.size(), 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edit_mem_shared_memory_mc.md
# edit_mem_shared_memory_mc

Multi-channel successor to the edit-memory packet buffer. Stores processing-unit (PU) write data and serves reads from NUM_RD independent dequeue channels through a round-robin arbiter, one RAM read per cycle. Adds same-cycle write-to-read forwarding and per-channel tagging of read data, and releases a buffer pointer when its last segment or the packet EOP is read. Sits between the PU write path and the per-port transmit/dequeue logic.

## Interface
- BPTR_NBITS, 10, buffer pointer width
- BPTR_LSB_NBITS, 2, segment-within-buffer index width
- DATA_NBITS, 512, data word width
- ID_NBITS, 3, destination port id width
- NUM_RD, 4, number of read channels (1..16); CH_NBITS = max(1, clog2(NUM_RD))

- clk  in  1  single clock; all logic rising-edge
- rstn  in  1  reset, synchronous, active-low
- pu_data_valid  in  1  write strobe
- pu_data_buf_ptr  in  BPTR_NBITS  write buffer pointer
- pu_data_buf_ptr_lsb  in  BPTR_LSB_NBITS  write segment index
- pu_data  in  DATA_NBITS  write data
- rd_req  in  NUM_RD  per-channel read request, level, held until granted
- rd_dst_port_id  in  NUM_RD*ID_NBITS  per-channel port id, channel c at [c*ID_NBITS +: ID_NBITS]
- rd_sop, rd_eop  in  NUM_RD each  per-channel SOP/EOP flags
- rd_buf_ptr  in  NUM_RD*BPTR_NBITS  per-channel buffer pointer
- rd_buf_ptr_lsb  in  NUM_RD*BPTR_LSB_NBITS  per-channel segment index
- rd_gnt  out  NUM_RD  one-hot grant, combinational, same cycle as accepted request
- edit_mem_ack  out  1  read data valid
- edit_mem_ack_ch  out  CH_NBITS  channel of returned data
- edit_mem_dst_port_id  out  ID_NBITS  port id of returned data
- edit_mem_sop, edit_mem_eop  out  1 each  flags of returned data
- edit_mem_rdata  out  DATA_NBITS  read data
- em_rel_buf_valid  out  1  buffer release strobe
- em_rel_buf_ptr  out  BPTR_NBITS  released pointer

## Operation
- Write path: PU inputs registered once (stage W1); RAM write at W1 to address {ptr, lsb}.
- Arbiter: round-robin over rd_req; priority starts at channel after last granted; reset pointer = channel 0 highest. At most one grant per cycle; rd_gnt = 0 when rd_req = 0. Pointer updates only on a grant.
- Granted request's fields muxed and registered into stage R1 (valid, ch, id, sop, eop, ptr, lsb); RAM read address = R1 {ptr, lsb}.
- Forwarding: if R1 valid, W1 valid and R1 address == W1 address in the same cycle, returned data is W1 data (new value), not RAM output. Forward flag and data carried to R2.
- Stage R2: ack, ch, id, sop, eop, rdata (RAM dout or forwarded data) registered to outputs.
- Release: em_rel_buf_valid asserted at R2 for a read whose lsb is all-ones OR eop = 1 (single strobe if both); em_rel_buf_ptr = that read's ptr.
- Reset: edit_mem_ack, em_rel_buf_valid, rd_gnt-related valid stages, W1 valid cleared to 0; RR pointer to 0; data/tag outputs 0. In-flight reads and writes discarded; RAM contents not cleared.

## Timing
- Request granted in cycle T -> edit_mem_ack, rdata, tags, release in cycle T+2. Fully pipelined: one ack per cycle sustained.
- Write presented cycle T -> readable by a read granted in cycle T (forward at W1/R1 match) or later.
- Write at T and read granted at T-1 to same address: read returns old data (no forward).
- rd_req deasserted before grant: no effect. Requester must not change fields while waiting.
- Reset asserted mid-stream: outputs 0 the cycle after the reset edge; first grant possible in the cycle rstn is sampled high.

## Test plan
- Single channel: write 0xA5.. to {ptr=5,lsb=0} at T, read ch0 at T+3 -> ack at T+5, rdata 0xA5.., ch=0, no release.
- All 4 channels request continuously -> grants 0,1,2,3,0,... one per cycle; ack_ch follows same order 2 cycles later.
- Forwarding: write 0x11.. to {7,1} at T, read {7,1} granted at T -> rdata 0x11..; read granted at T-1 -> old value.
- Release: read lsb=3, eop=0 -> release ptr; lsb=1, eop=1 -> release; lsb=3, eop=1 -> exactly one strobe; lsb=0, eop=0 -> none.
- Reset mid-operation: pull rstn low with 2 reads in flight -> no ack/release afterwards, next grant to channel 0 first.
- NUM_RD=1 and DATA_NBITS=64 build: back-to-back reads return correct data each cycle.
